// File: rtl/audio_pkg.sv
// Shared constants and types for the audio sample path: I2S frame geometry,
// sample layout and a slot-to-channel helper.
package audio_pkg;

    localparam int AUDIO_SLOTS         = 32;
    localparam int AUDIO_CH_W          = 16;
    localparam int AUDIO_SAMPLE_W      = 32;
    localparam int AUDIO_FETCH_SLOT    = 1;
    localparam int AUDIO_WS_RIGHT_SLOT = 16;
    localparam int AUDIO_SLOT_W        = $clog2(AUDIO_SLOTS);

    typedef logic [AUDIO_SLOT_W-1:0]   slot_t;
    typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

    // Word select is high for the right-channel half of the frame.
    function automatic logic is_right_slot(input slot_t slot);
        return slot >= slot_t'(AUDIO_WS_RIGHT_SLOT);
    endfunction

endpackage

// File: rtl/audio_sck_gen.sv
// I2S bit-clock generator: a 0..limit divider that toggles SCK at terminal
// count, plus single-cycle strobes announcing the rising and falling toggles.
module audio_sck_gen #(
    parameter int CLK_DIV_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [CLK_DIV_W-1:0] clk_div_i,
    output logic                 sck_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic [CLK_DIV_W-1:0] limit_q, limit_d;
    logic [CLK_DIV_W-1:0] limit;
    logic                 sck_q, sck_d;
    logic                 run_q, run_d;
    logic                 tc;

    // Divider next state; the first half-period after idle compares against
    // clk_div_i directly, later ones against the value latched at the last toggle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        limit   = run_q ? limit_q : clk_div_i;
        tc      = enable_i && (div_q == limit);
        rise_o  = tc && !sck_q;
        fall_o  = tc && sck_q;
        div_d   = div_q;
        limit_d = limit_q;
        sck_d   = sck_q;
        run_d   = run_q;
        if (!enable_i) begin
            div_d   = '0;
            limit_d = '0;
            sck_d   = 1'b0;
            run_d   = 1'b0;
        end else begin
            run_d = 1'b1;
            if (!run_q || tc) begin
                limit_d = clk_div_i;
            end
            if (tc) begin
                div_d = '0;
                sck_d = !sck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Divider and bit-clock registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            limit_q <= '0;
            sck_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            div_q   <= div_d;
            limit_q <= limit_d;
            sck_q   <= sck_d;
            run_q   <= run_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter draining the audio sample FIFO: one 32-bit stereo
// sample per 32-slot frame, MSB first with the one-bit I2S delay, bus master
// for SCK/WS. An empty FIFO at fetch time sends silence and flags underrun.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [CLK_DIV_W-1:0]      clk_div_i,
    input  logic [AUDIO_SAMPLE_W-1:0] data_i,
    input  logic                      valid_i,
    output logic                      pop_o,
    output logic                      i2s_sck_o,
    output logic                      i2s_ws_o,
    output logic                      i2s_sd_o,
    output logic                      underrun_o
);

    logic    sck_rise;
    logic    sck_fall;
    slot_t   slot_q, slot_d;
    sample_t shift_q, shift_d;
    logic    ws_q, ws_d;
    logic    pop_q, pop_d;
    logic    underrun_q, underrun_d;

    audio_sck_gen #(
        .CLK_DIV_W (CLK_DIV_W)
    ) u_sck_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable_i  (enable_i),
        .clk_div_i (clk_div_i),
        .sck_o     (i2s_sck_o),
        .rise_o    (sck_rise),
        .fall_o    (sck_fall)
    );

    // Frame sequencing: every falling toggle moves to the next slot and either
    // fetches a new sample (entering the fetch slot) or shifts out one bit.
    always_comb begin
        slot_d     = slot_q;
        shift_d    = shift_q;
        ws_d       = ws_q;
        pop_d      = 1'b0;
        underrun_d = 1'b0;
        if (!enable_i) begin
            slot_d  = '0;
            shift_d = '0;
            ws_d    = 1'b0;
        end else if (sck_fall) begin
            slot_d = slot_q + 1'b1;
            ws_d   = is_right_slot(slot_d);
            if (slot_d == slot_t'(AUDIO_FETCH_SLOT)) begin
                if (valid_i) begin
                    shift_d = data_i;
                    pop_d   = 1'b1;
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = {shift_q[AUDIO_SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    // Frame state and registered handshake/status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            shift_q    <= '0;
            ws_q       <= 1'b0;
            pop_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            ws_q       <= ws_d;
            pop_q      <= pop_d;
            underrun_q <= underrun_d;
        end
    end

    // A single toggle is either a rise or a fall, never both.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(sck_rise && sck_fall));
        end
    end

    assign pop_o      = pop_q;
    assign underrun_o = underrun_q;
    assign i2s_ws_o   = ws_q;
    assign i2s_sd_o   = shift_q[AUDIO_SAMPLE_W-1];

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx. A FIFO model feeds the DUT; a
// reference model predicts SCK toggles from the half-period schedule, frames
// from the count of falling edges, and serial bits from the fetched samples.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [7:0]  clk_div_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        pop_o;
    logic        i2s_sck_o;
    logic        i2s_ws_o;
    logic        i2s_sd_o;
    logic        underrun_o;

    int checks = 0;
    int errors = 0;

    // FIFO contents as seen by the DUT, and the model's own copy.
    logic [31:0] q[$];
    logic [31:0] mq[$];
    // Samples the model expects to be framed, one per fetch.
    logic [31:0] fr[$];

    int   m_ticks = 0;
    int   m_next  = 0;
    int   m_falls = 0;
    logic m_sck   = 1'b0;
    logic m_pop   = 1'b0;
    logic m_und   = 1'b0;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .CLK_DIV_W (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .clk_div_i  (clk_div_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .pop_o      (pop_o),
        .i2s_sck_o  (i2s_sck_o),
        .i2s_ws_o   (i2s_ws_o),
        .i2s_sd_o   (i2s_sd_o),
        .underrun_o (underrun_o)
    );

    task automatic drive_fifo();
        valid_i = (q.size() > 0);
        data_i  = valid_i ? q[0] : $urandom();
    endtask

    task automatic push(input logic [31:0] s);
        q.push_back(s);
        mq.push_back(s);
        drive_fifo();
    endtask

    // One clock: update the model for this edge, sample the DUT 1 time unit
    // later and service the FIFO. Returns {sck, ws, sd, pop, underrun}.
    task automatic advance(output logic [4:0] got, output logic [4:0] want);
        logic        en;
        int          d;
        int          idx;
        int          slot;
        logic [31:0] w;
        logic [4:0]  bi;
        en = enable_i && !rst_i;
        d  = int'(clk_div_i);
        @(posedge clk);
        m_pop = 1'b0;
        m_und = 1'b0;
        if (!en) begin
            m_ticks = 0;
            m_sck   = 1'b0;
            m_falls = 0;
            fr.delete();
        end else begin
            m_ticks++;
            if (m_ticks == 1) m_next = d + 1;
            if (m_ticks == m_next) begin
                m_next = m_ticks + d + 1;
                m_sck  = ~m_sck;
                if (!m_sck) begin
                    m_falls++;
                    if (m_falls % 32 == 1) begin
                        if (mq.size() > 0) begin
                            fr.push_back(mq.pop_front());
                            m_pop = 1'b1;
                        end else begin
                            fr.push_back(32'h0);
                            m_und = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        slot = m_falls % 32;
        idx  = (m_falls - 1) / 32;
        w    = 32'h0;
        if (m_falls > 0 && idx < fr.size()) w = fr[idx];
        bi   = 5'((32 - slot) % 32);
        want = {m_sck, (slot >= 16), w[bi], m_pop, m_und};
        got  = {i2s_sck_o, i2s_ws_o, i2s_sd_o, pop_o, underrun_o};
        if (pop_o && q.size() > 0) q.delete(0);
        drive_fifo();
    endtask

    task automatic go_idle();
        logic [4:0] got, want;
        enable_i = 1'b0;
        advance(got, want);
        advance(got, want);
        q.delete();
        mq.delete();
        drive_fifo();
    endtask

    task automatic test_reset();
        logic [4:0] got, want;
        rst_i     = 1'b1;
        enable_i  = 1'b1;
        clk_div_i = 8'd0;
        push(32'hDEAD_BEEF);
        #1;
        got = {i2s_sck_o, i2s_ws_o, i2s_sd_o, pop_o, underrun_o};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000", got);
        end
        for (int i = 0; i < 4; i++) begin
            advance(got, want);
            checks++;
            if (got !== 5'b0 || got !== want) begin
                errors++;
                $display("FAIL reset_held cyc %0d got %b want %b", i, got, want);
            end
        end
        rst_i = 1'b0;
        go_idle();
    endtask

    task automatic test_basic();
        logic [4:0]  got, want;
        logic [31:0] word;
        int          first_pop;
        logic        ws31, ws32;
        word      = 32'h0;
        first_pop = -1;
        ws31      = 1'bx;
        ws32      = 1'bx;
        clk_div_i = 8'd0;
        push(32'h8001_7FFE);
        push(32'h1234_5678);
        enable_i = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL basic n=%0d got %b want %b", n, got, want);
            end
            if (got[1] && first_pop < 0) first_pop = n;
            if (n % 2 == 0 && n >= 2 && n <= 64) word[(32 - n / 2) % 32] = i2s_sd_o;
            if (n == 31) ws31 = i2s_ws_o;
            if (n == 32) ws32 = i2s_ws_o;
        end
        checks++;
        if (first_pop !== 2) begin
            errors++;
            $display("FAIL basic_first_pop got %0d want 2", first_pop);
        end
        checks++;
        if (word !== 32'h8001_7FFE) begin
            errors++;
            $display("FAIL basic_stream got %h want 80017ffe", word);
        end
        checks++;
        if ({ws31, ws32} !== 2'b01) begin
            errors++;
            $display("FAIL basic_ws_edge got %b want 01", {ws31, ws32});
        end
        go_idle();
    endtask

    task automatic test_div3();
        logic [4:0]  got, want;
        logic [31:0] words[2];
        int          pops[$];
        int          rises[$];
        logic        prev_sck;
        words[0]  = 32'h0;
        words[1]  = 32'h0;
        prev_sck  = 1'b0;
        clk_div_i = 8'd3;
        push(32'hAAAA_5555);
        push(32'h0000_FFFF);
        enable_i = 1'b1;
        for (int n = 1; n <= 516; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL div3 n=%0d got %b want %b", n, got, want);
            end
            if (got[1]) pops.push_back(n);
            if (got[4] && !prev_sck) rises.push_back(n);
            prev_sck = got[4];
            if (n % 8 == 0) begin
                int k, s;
                s = (n / 8 - 1) % 32 + 1;
                k = (n / 8 - 1) / 32;
                if (k < 2) words[k][(32 - s) % 32] = i2s_sd_o;
            end
        end
        checks++;
        if (pops.size() != 2 || pops[1] - pops[0] != 256) begin
            errors++;
            $display("FAIL div3_pop_spacing got %0d pops first %0d want 2 pops 256 apart",
                     pops.size(), (pops.size() > 0) ? pops[0] : -1);
        end
        checks++;
        if (rises.size() < 2 || rises[0] != 4 || rises[1] - rises[0] != 8) begin
            errors++;
            $display("FAIL div3_sck_period got first rise %0d count %0d want rise 4 period 8",
                     (rises.size() > 0) ? rises[0] : -1, rises.size());
        end
        checks++;
        if (words[0] !== 32'hAAAA_5555 || words[1] !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL div3_stream got %h %h want aaaa5555 0000ffff", words[0], words[1]);
        end
        go_idle();
    endtask

    task automatic test_underrun();
        logic [4:0] got, want;
        int         h, pops, unds, ones;
        clk_div_i = 8'($urandom_range(0, 2));
        h    = int'(clk_div_i) + 1;
        pops = 0;
        unds = 0;
        ones = 0;
        push($urandom());
        enable_i = 1'b1;
        for (int n = 1; n <= 2 * h * 65 + 2; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL underrun n=%0d got %b want %b", n, got, want);
            end
            if (n == 2 * h * 40) push($urandom());
            if (got[1]) pops++;
            if (got[0]) unds++;
            if (n >= 2 * h * 33 && n < 2 * h * 64 && got[2]) ones++;
        end
        checks++;
        if (unds != 1 || pops != 2) begin
            errors++;
            $display("FAIL underrun_counts got und %0d pop %0d want und 1 pop 2", unds, pops);
        end
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL underrun_silence got %0d one-bits want 0", ones);
        end
        go_idle();
    endtask

    task automatic test_disable();
        logic [4:0]  got, want;
        logic [31:0] b;
        logic [31:0] word;
        int          h, first_pop;
        clk_div_i = 8'($urandom_range(0, 2));
        h         = int'(clk_div_i) + 1;
        b         = $urandom();
        word      = 32'h0;
        first_pop = -1;
        push($urandom());
        push(b);
        push($urandom());
        enable_i = 1'b1;
        for (int n = 1; n <= 2 * h * 9 + 1; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL disable_run n=%0d got %b want %b", n, got, want);
            end
        end
        enable_i = 1'b0;
        advance(got, want);
        checks++;
        if (got !== 5'b0 || got !== want) begin
            errors++;
            $display("FAIL disable_idle got %b want 00000", got);
        end
        for (int i = 0; i < 3; i++) advance(got, want);
        enable_i = 1'b1;
        for (int n = 1; n <= 2 * h * 34 + 2; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL disable_reenable n=%0d got %b want %b", n, got, want);
            end
            if (got[1] && first_pop < 0) first_pop = n;
            if (n % (2 * h) == 0 && n <= 2 * h * 32) word[(32 - n / (2 * h)) % 32] = i2s_sd_o;
        end
        checks++;
        if (first_pop != 2 * h) begin
            errors++;
            $display("FAIL disable_first_fetch got %0d want %0d", first_pop, 2 * h);
        end
        checks++;
        if (word !== b) begin
            errors++;
            $display("FAIL disable_next_word got %h want %h", word, b);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        logic [4:0] got, want;
        clk_div_i = 8'd1;
        push($urandom());
        push($urandom());
        push($urandom());
        enable_i = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL async_run n=%0d got %b want %b", n, got, want);
            end
        end
        #3;
        rst_i = 1'b1;
        #1;
        got = {i2s_sck_o, i2s_ws_o, i2s_sd_o, pop_o, underrun_o};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL async_immediate got %b want 00000", got);
        end
        for (int i = 0; i < 4; i++) begin
            advance(got, want);
            checks++;
            if (pop_o !== 1'b0 || got !== want) begin
                errors++;
                $display("FAIL async_held cyc %0d got %b want %b", i, got, want);
            end
        end
        rst_i = 1'b0;
        for (int n = 1; n <= 2 * 2 * 34; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL async_resume n=%0d got %b want %b", n, got, want);
            end
        end
        go_idle();
    endtask

    task automatic test_div_change();
        logic [4:0] got, want;
        int         toggles[$];
        logic       prev_sck;
        clk_div_i = 8'd1;
        push($urandom());
        push($urandom());
        push($urandom());
        enable_i = 1'b1;
        prev_sck = 1'b0;
        for (int n = 1; n <= 37 + 3 * 2 * 66; n++) begin
            advance(got, want);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL divchg n=%0d got %b want %b", n, got, want);
            end
            if (n > 37 && got[4] != prev_sck) toggles.push_back(n);
            prev_sck = got[4];
            if (n == 37) clk_div_i = 8'd2;
        end
        checks++;
        if (toggles.size() < 3 || toggles[0] != 38 || toggles[1] != 41 || toggles[2] != 44) begin
            errors++;
            $display("FAIL divchg_toggles got %0d %0d %0d want 38 41 44",
                     (toggles.size() > 0) ? toggles[0] : -1,
                     (toggles.size() > 1) ? toggles[1] : -1,
                     (toggles.size() > 2) ? toggles[2] : -1);
        end
        go_idle();
    endtask

    initial begin
        rst_i     = 1'b1;
        enable_i  = 1'b0;
        clk_div_i = 8'd0;
        valid_i   = 1'b0;
        data_i    = 32'h0;
        test_reset();
        test_basic();
        test_div3();
        test_underrun();
        test_disable();
        test_async_reset();
        test_div_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Drain side of the audio sample FIFO. Pops one 32-bit stereo sample per frame from the FIFO read port (`valid`/`pop` with data valid in the same cycle), serialises it as Philips I2S (16-bit left and 16-bit right, 32 bit clocks per frame), and generates SCK/WS as bus master. An empty FIFO at frame fetch outputs silence and pulses an underrun flag for the controller's status logic.

## Interface
- `CLK_DIV_W`, default 8: width of the bit-clock divider input.
- `clk_i`  in  1  system clock; every output is registered on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  transmitter enable from the control register.
- `clk_div_i`  in  CLK_DIV_W  SCK half-period minus one, in `clk_i` cycles.
- `data_i`  in  32  FIFO head sample: [31:16] left, [15:0] right, two's complement.
- `valid_i`  in  1  FIFO head valid.
- `pop_o`  out  1  one-cycle pop strobe; consumes `data_i` in the same cycle.
- `i2s_sck_o`  out  1  bit clock.
- `i2s_ws_o`  out  1  word select: 0 = left, 1 = right.
- `i2s_sd_o`  out  1  serial data, MSB first.
- `underrun_o`  out  1  one-cycle pulse when a frame is fetched with `valid_i` low.

## Operation
- Reset or `enable_i` low puts the block in idle. Idle values: divider = 0, `sck` = 0, slot = 0, shift register = 0. All outputs are 0.
- Divider:
  - Counts 0..`clk_div_i`. At the terminal count it wraps to 0 and toggles `sck`.
  - SCK period = 2*(`clk_div_i`+1) clocks.
  - `clk_div_i` is sampled only at terminal count. A change takes effect at the next toggle.
- Slot counter is 5 bits, 0..31, and wraps 31 -> 0. It advances only on the falling toggle (`sck` 1 -> 0).
- `i2s_ws_o` = 0 for slots 0..15 and 1 for slots 16..31. It updates on the same clock edge as the falling toggle.
- Data path: 32-bit shift register. `i2s_sd_o` = shift[31].
  - On each falling toggle entering slot s != 1: shift left by one, filling with 0.
  - On the falling toggle entering slot 1 (fetch):
    - If `valid_i` = 1: load `data_i` and assert `pop_o` that cycle.
    - If `valid_i` = 0: load 0 and assert `underrun_o` that cycle. `pop_o` stays 0.
- Resulting bit placement:
  - Slot 0 carries the previous right LSB (I2S one-bit delay).
  - Slots 1..16 carry left[15:0].
  - Slots 17..31 carry right[15:1].
  - Right[0] appears in slot 0 of the next frame.
- The first frame after enable emits a 0 in slot 0. The first fetch happens on the first falling toggle.
- `pop_o` and `underrun_o` are mutually exclusive. At most one of them fires per frame.
- Deasserting `enable_i` mid-frame returns to idle on the next clock. The partially sent sample is discarded and never re-popped.
- Asynchronous reset mid-frame: same end state as disable, applied immediately.

## Timing
- After enable: first SCK rise at clock `clk_div_i`+1, first fall and first fetch at 2*(`clk_div_i`+1).
- Frame = 64*(`clk_div_i`+1) clocks. `pop_o` fires exactly once per frame while the FIFO is non-empty.
- `sd` and `ws` change on the clock edge where `sck` falls. The receiver samples on the SCK rise, (`clk_div_i`+1) clocks later.
- `clk_div_i` = 0 gives SCK = clk/2. This is the minimum and must be supported.

## Structure
- Shared `audio_pkg` holds:
  - `AUDIO_SLOTS` = 32, `AUDIO_CH_W` = 16, `AUDIO_SAMPLE_W` = 32.
  - `AUDIO_FETCH_SLOT` = 1, `AUDIO_WS_RIGHT_SLOT` = 16.
- One sub-module: `audio_sck_gen`. It contains the divider and the `sck` register, and outputs `sck` plus rise/fall strobes. Frame, shift and handshake logic stay in `audio_i2s_tx`.

## Test plan
- `clk_div_i`=0, FIFO presents 0x8001_7FFE:
  - `pop_o` fires at clock 2.
  - Slots 1..16 carry 1000_0000_0000_0001.
  - Slots 17..31 plus next slot 0 carry 0111_1111_1111_1110.
  - `i2s_ws_o` rises entering slot 16.
- `clk_div_i`=3, two queued samples 0xAAAA_5555 and 0x0000_FFFF:
  - SCK period is 8 clocks.
  - The two `pop_o` pulses are exactly 256 clocks apart.
  - Serial stream matches both samples bit-exact.
- `valid_i` low at fetch:
  - `underrun_o` pulses once and `pop_o` stays 0.
  - Slots 1..31 of that frame are 0.
  - The next frame with `valid_i` high pops normally.
- `enable_i` dropped at slot 9:
  - All outputs are 0 on the next clock.
  - On re-enable, the first fetch is at clock 2*(`clk_div_i`+1) and pops the next FIFO word.
- `rst_i` asserted asynchronously mid-frame, between clock edges:
  - Outputs go to 0 without waiting for a clock edge.
  - No `pop_o` while reset is held.
- `clk_div_i` changed 1 -> 2 mid-frame: the new half-period of 3 clocks applies from the next toggle. There are no glitches and no extra pops.
